// File: rtl/calib_master_fsm.sv
// rtl/calib_master_fsm.sv - master-side AIB link bring-up sequencer
// Config, wake-up, DCC/DLL lock handshake, with per-attempt timeout, bounded retry and link-loss detection.
module calib_master_fsm #(
  parameter int TOTAL_CHNL_NUM = 24,
  parameter int CLK_FREQ_MHZ   = 100,
  parameter int TIMEOUT_US     = 1000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [TOTAL_CHNL_NUM-1:0] chnl_mask_i,
  output logic                      cfg_start_o,
  input  logic                      cfg_done_i,
  output logic                      i_conf_done,
  output logic [TOTAL_CHNL_NUM-1:0] ns_mac_rdy,
  output logic [TOTAL_CHNL_NUM-1:0] ns_adapter_rstn,
  output logic [TOTAL_CHNL_NUM-1:0] ms_rx_dcc_dll_lock_req,
  output logic [TOTAL_CHNL_NUM-1:0] ms_tx_dcc_dll_lock_req,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] ms_rx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_tx_transfer_en,
  input  logic [TOTAL_CHNL_NUM-1:0] sl_rx_transfer_en,
  output logic                      link_up_o,
  output logic                      fail_o,
  output logic                      link_lost_o,
  output logic [1:0]                retry_cnt_o,
  output logic [2:0]                state_o
);

  localparam int DLY   = CLK_FREQ_MHZ;
  localparam int TMO   = TIMEOUT_US * CLK_FREQ_MHZ;
  localparam int MAXC  = (DLY > TMO) ? DLY : TMO;
  localparam int CNT_W = $clog2(MAXC) + 1;
  localparam logic [CNT_W-1:0] DLY_END = CNT_W'(DLY - 1);
  localparam logic [CNT_W-1:0] TMO_END = CNT_W'(TMO - 1);
  localparam logic [2:0]       MAX_R   = 3'((MAX_RETRY > 3) ? 3 : MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONFIG   = 3'd1,
    S_WAKEUP   = 3'd2,
    S_LOCK_REQ = 3'd3,
    S_LINK_UP  = 3'd4,
    S_BACKOFF  = 3'd5,
    S_FAIL     = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [TOTAL_CHNL_NUM-1:0] mask_q, mask_d;
  logic [1:0]                retry_cnt_q, retry_cnt_d;
  logic                      link_lost_q, link_lost_d;
  logic                      cfg_start_q, cfg_start_d;
  logic                      conf_done_q, conf_done_d;
  logic [TOTAL_CHNL_NUM-1:0] mac_rdy_q, mac_rdy_d;
  logic [TOTAL_CHNL_NUM-1:0] adapter_rstn_q, adapter_rstn_d;
  logic [TOTAL_CHNL_NUM-1:0] lock_req_q, lock_req_d;
  logic                      link_up_q, link_up_d;
  logic                      fail_q, fail_d;

  logic done_all;
  logic retry_ok;
  logic lock_phase;

  // Masked-off channels are forced true so they never hold the link down.
  assign done_all = &((ms_tx_transfer_en & ms_rx_transfer_en &
                       sl_tx_transfer_en & sl_rx_transfer_en) | ~mask_q);
  assign retry_ok = ({1'b0, retry_cnt_q} < MAX_R);

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    retry_cnt_d = retry_cnt_q;
    link_lost_d = link_lost_q;

    case (state_q)
      S_IDLE, S_FAIL: begin
        if (start_i && (|chnl_mask_i)) begin
          state_d     = S_CONFIG;
          mask_d      = chnl_mask_i;
          retry_cnt_d = 2'd0;
          link_lost_d = 1'b0;
        end
      end
      S_CONFIG: begin
        if (cfg_done_i) state_d = S_WAKEUP;
      end
      S_WAKEUP: begin
        if (cnt_q == DLY_END) state_d = S_LOCK_REQ;
      end
      S_LOCK_REQ: begin
        if (done_all) state_d = S_LINK_UP;
        else if (cnt_q == TMO_END) state_d = retry_ok ? S_BACKOFF : S_FAIL;
      end
      S_LINK_UP: begin
        if (!done_all) begin
          link_lost_d = 1'b1;
          state_d     = retry_ok ? S_BACKOFF : S_FAIL;
        end
      end
      S_BACKOFF: begin
        if (cnt_q == DLY_END) state_d = S_WAKEUP;
      end
      default: state_d = S_IDLE;
    endcase

    if ((state_d == S_BACKOFF) && (state_q != S_BACKOFF) && (retry_cnt_q != 2'd3))
      retry_cnt_d = retry_cnt_q + 2'd1;

    cnt_d = (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);

    // Outputs decode the state being entered so they move on the same edge.
    lock_phase     = (state_d == S_LOCK_REQ) || (state_d == S_LINK_UP);
    cfg_start_d    = (state_d == S_CONFIG);
    conf_done_d    = (state_d inside {S_WAKEUP, S_LOCK_REQ, S_LINK_UP, S_BACKOFF, S_FAIL});
    mac_rdy_d      = {TOTAL_CHNL_NUM{conf_done_d}};
    adapter_rstn_d = {TOTAL_CHNL_NUM{lock_phase}};
    lock_req_d     = lock_phase ? mask_d : '0;
    link_up_d      = (state_d == S_LINK_UP);
    fail_d         = (state_d == S_FAIL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      retry_cnt_q    <= 2'd0;
      link_lost_q    <= 1'b0;
      cfg_start_q    <= 1'b0;
      conf_done_q    <= 1'b0;
      mac_rdy_q      <= '0;
      adapter_rstn_q <= '0;
      lock_req_q     <= '0;
      link_up_q      <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      retry_cnt_q    <= retry_cnt_d;
      link_lost_q    <= link_lost_d;
      cfg_start_q    <= cfg_start_d;
      conf_done_q    <= conf_done_d;
      mac_rdy_q      <= mac_rdy_d;
      adapter_rstn_q <= adapter_rstn_d;
      lock_req_q     <= lock_req_d;
      link_up_q      <= link_up_d;
      fail_q         <= fail_d;
    end
  end

  assign cfg_start_o            = cfg_start_q;
  assign i_conf_done            = conf_done_q;
  assign ns_mac_rdy             = mac_rdy_q;
  assign ns_adapter_rstn        = adapter_rstn_q;
  assign ms_rx_dcc_dll_lock_req = lock_req_q;
  assign ms_tx_dcc_dll_lock_req = lock_req_q;
  assign link_up_o              = link_up_q;
  assign fail_o                 = fail_q;
  assign link_lost_o            = link_lost_q;
  assign retry_cnt_o            = retry_cnt_q;
  assign state_o                = state_q;

endmodule

// File: tb/tb_calib_master_fsm.sv
// tb/tb_calib_master_fsm.sv - directed bench for calib_master_fsm
// DLY=10, TMO=20, MAX_RETRY=2 on a 4-channel build.
module tb_calib_master_fsm;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [N-1:0] chnl_mask_i;
  logic         cfg_start_o;
  logic         cfg_done_i;
  logic         i_conf_done;
  logic [N-1:0] ns_mac_rdy;
  logic [N-1:0] ns_adapter_rstn;
  logic [N-1:0] ms_rx_dcc_dll_lock_req;
  logic [N-1:0] ms_tx_dcc_dll_lock_req;
  logic [N-1:0] ms_tx_transfer_en;
  logic [N-1:0] ms_rx_transfer_en;
  logic [N-1:0] sl_tx_transfer_en;
  logic [N-1:0] sl_rx_transfer_en;
  logic         link_up_o;
  logic         fail_o;
  logic         link_lost_o;
  logic [1:0]   retry_cnt_o;
  logic [2:0]   state_o;

  int n_tests = 0;
  int n_fail  = 0;

  calib_master_fsm #(
    .TOTAL_CHNL_NUM(N), .CLK_FREQ_MHZ(10), .TIMEOUT_US(2), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .chnl_mask_i(chnl_mask_i),
    .cfg_start_o(cfg_start_o), .cfg_done_i(cfg_done_i), .i_conf_done(i_conf_done),
    .ns_mac_rdy(ns_mac_rdy), .ns_adapter_rstn(ns_adapter_rstn),
    .ms_rx_dcc_dll_lock_req(ms_rx_dcc_dll_lock_req),
    .ms_tx_dcc_dll_lock_req(ms_tx_dcc_dll_lock_req),
    .ms_tx_transfer_en(ms_tx_transfer_en), .ms_rx_transfer_en(ms_rx_transfer_en),
    .sl_tx_transfer_en(sl_tx_transfer_en), .sl_rx_transfer_en(sl_rx_transfer_en),
    .link_up_o(link_up_o), .fail_o(fail_o), .link_lost_o(link_lost_o),
    .retry_cnt_o(retry_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input logic [N-1:0] v);
    ms_tx_transfer_en = v;
    ms_rx_transfer_en = v;
    sl_tx_transfer_en = v;
    sl_rx_transfer_en = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start_i = 1'b0; chnl_mask_i = '0; cfg_done_i = 1'b0;
    set_en('0);
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // Counts edges until state_o leaves s; -1 if the budget runs out.
  task automatic dwell(input logic [2:0] s, input int budget, output int n);
    n = 0;
    while (state_o == s && n < budget) begin
      step();
      n++;
    end
    if (state_o == s) n = -1;
  endtask

  task automatic to_lockreq(input logic [N-1:0] m, output int wake_n);
    do_reset();
    start_i = 1'b1; chnl_mask_i = m;
    step();
    start_i = 1'b0; cfg_done_i = 1'b1;
    step();
    cfg_done_i = 1'b0;
    dwell(3'd2, 40, wake_n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start_i = 1'b1; chnl_mask_i = 4'hF; cfg_done_i = 1'b1;
    set_en(4'hF);
    step(); step();
    n_tests++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
    n_tests++;
    if ({cfg_start_o, i_conf_done, ns_mac_rdy, ns_adapter_rstn, ms_rx_dcc_dll_lock_req,
         ms_tx_dcc_dll_lock_req, link_up_o, fail_o, link_lost_o, retry_cnt_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: some output nonzero during reset");
    end
    do_reset();
  endtask

  task automatic test_happy();
    int n;
    do_reset();
    start_i = 1'b1; chnl_mask_i = 4'hF;
    step();
    start_i = 1'b0;
    n_tests++;
    if (state_o !== 3'd1 || cfg_start_o !== 1'b1) begin
      n_fail++; $display("FAIL happy_config: state %0d cfg_start %0b want 1/1", state_o, cfg_start_o);
    end
    step(); step();
    cfg_done_i = 1'b1;
    step();
    cfg_done_i = 1'b0;
    n_tests++;
    if (i_conf_done !== 1'b1 || ns_mac_rdy !== 4'hF || ns_adapter_rstn !== 4'h0 || cfg_start_o !== 1'b0) begin
      n_fail++; $display("FAIL happy_wakeup: conf_done %0b mac_rdy %h rstn %h want 1/F/0", i_conf_done, ns_mac_rdy, ns_adapter_rstn);
    end
    n = 0;
    while (ns_adapter_rstn == 4'h0 && n < 40) begin step(); n++; end
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL happy_rstn_delay: got %0d cycles want 10", n); end
    n_tests++;
    if (state_o !== 3'd3 || ms_rx_dcc_dll_lock_req !== 4'hF || ms_tx_dcc_dll_lock_req !== 4'hF) begin
      n_fail++; $display("FAIL happy_lockreq: state %0d rx %h tx %h want 3/F/F", state_o, ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req);
    end
    repeat (4) step();
    n_tests++;
    if (link_up_o !== 1'b0) begin n_fail++; $display("FAIL happy_early_link: got %0b want 0", link_up_o); end
    set_en(4'hF);
    step();
    n_tests++;
    if (link_up_o !== 1'b1 || state_o !== 3'd4 || retry_cnt_o !== 2'd0 || ns_adapter_rstn !== 4'hF) begin
      n_fail++; $display("FAIL happy_link_up: link %0b state %0d retry %0d want 1/4/0", link_up_o, state_o, retry_cnt_o);
    end
  endtask

  task automatic test_mask();
    int n;
    to_lockreq(4'b0101, n);
    n_tests++;
    if (n !== 10) begin n_fail++; $display("FAIL mask_wakeup_len: got %0d want 10", n); end
    n_tests++;
    if (ms_rx_dcc_dll_lock_req !== 4'b0101 || ms_tx_dcc_dll_lock_req !== 4'b0101) begin
      n_fail++; $display("FAIL mask_lockreq: rx %b tx %b want 0101", ms_rx_dcc_dll_lock_req, ms_tx_dcc_dll_lock_req);
    end
    set_en(4'b0101);
    step();
    n_tests++;
    if (state_o !== 3'd4 || link_up_o !== 1'b1) begin
      n_fail++; $display("FAIL mask_link_up: state %0d link %0b want 4/1", state_o, link_up_o);
    end
    do_reset();
    start_i = 1'b1; chnl_mask_i = 4'h0;
    step();
    start_i = 1'b0;
    step();
    n_tests++;
    if (state_o !== 3'd0 || cfg_start_o !== 1'b0) begin
      n_fail++; $display("FAIL mask_zero_start: state %0d cfg_start %0b want 0/0", state_o, cfg_start_o);
    end
  endtask

  task automatic test_timeout_retry();
    int n;
    to_lockreq(4'hF, n);
    dwell(3'd3, 40, n);
    n_tests++;
    if (n !== 20) begin n_fail++; $display("FAIL tmo_lock_len1: got %0d want 20", n); end
    n_tests++;
    if (state_o !== 3'd5 || retry_cnt_o !== 2'd1 || ms_rx_dcc_dll_lock_req !== 4'h0 ||
        ns_adapter_rstn !== 4'h0 || i_conf_done !== 1'b1) begin
      n_fail++; $display("FAIL tmo_backoff1: state %0d retry %0d lock %h want 5/1/0", state_o, retry_cnt_o, ms_rx_dcc_dll_lock_req);
    end
    dwell(3'd5, 40, n);
    n_tests++;
    if (n !== 10 || state_o !== 3'd2 || cfg_start_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_backoff_len: got %0d cycles state %0d want 10/2", n, state_o);
    end
    dwell(3'd2, 40, n);
    dwell(3'd3, 40, n);
    n_tests++;
    if (n !== 20 || state_o !== 3'd5 || retry_cnt_o !== 2'd2) begin
      n_fail++; $display("FAIL tmo_backoff2: len %0d state %0d retry %0d want 20/5/2", n, state_o, retry_cnt_o);
    end
    dwell(3'd5, 40, n);
    dwell(3'd2, 40, n);
    dwell(3'd3, 40, n);
    n_tests++;
    if (n !== 20 || state_o !== 3'd6 || fail_o !== 1'b1 || retry_cnt_o !== 2'd2 ||
        i_conf_done !== 1'b1 || ns_mac_rdy !== 4'hF || ms_tx_dcc_dll_lock_req !== 4'h0 || link_up_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_fail: len %0d state %0d fail %0b retry %0d want 20/6/1/2", n, state_o, fail_o, retry_cnt_o);
    end
    start_i = 1'b1; chnl_mask_i = 4'hF;
    step();
    start_i = 1'b0;
    n_tests++;
    if (state_o !== 3'd1 || retry_cnt_o !== 2'd0 || fail_o !== 1'b0) begin
      n_fail++; $display("FAIL tmo_restart: state %0d retry %0d fail %0b want 1/0/0", state_o, retry_cnt_o, fail_o);
    end
  endtask

  task automatic test_tie();
    int n;
    to_lockreq(4'hF, n);
    repeat (19) step();
    n_tests++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL tie_pre: state %0d want 3", state_o); end
    set_en(4'hF);
    step();
    n_tests++;
    if (state_o !== 3'd4 || link_up_o !== 1'b1 || retry_cnt_o !== 2'd0) begin
      n_fail++; $display("FAIL tie_link_up: state %0d link %0b retry %0d want 4/1/0", state_o, link_up_o, retry_cnt_o);
    end
  endtask

  task automatic test_link_loss();
    int n;
    to_lockreq(4'hF, n);
    set_en(4'hF);
    step();
    sl_rx_transfer_en = 4'b1101;
    step();
    n_tests++;
    if (link_up_o !== 1'b0 || link_lost_o !== 1'b1 || state_o !== 3'd5 || retry_cnt_o !== 2'd1) begin
      n_fail++; $display("FAIL loss_detect: link %0b lost %0b state %0d retry %0d want 0/1/5/1", link_up_o, link_lost_o, state_o, retry_cnt_o);
    end
    sl_rx_transfer_en = 4'hF;
    dwell(3'd5, 40, n);
    dwell(3'd2, 40, n);
    dwell(3'd3, 40, n);
    n_tests++;
    if (n !== 1 || state_o !== 3'd4 || link_up_o !== 1'b1 || retry_cnt_o !== 2'd1 || link_lost_o !== 1'b1) begin
      n_fail++; $display("FAIL loss_recover: len %0d state %0d link %0b retry %0d lost %0b want 1/4/1/1/1", n, state_o, link_up_o, retry_cnt_o, link_lost_o);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    to_lockreq(4'hF, n);
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (state_o !== 3'd0 || i_conf_done !== 1'b0 || ns_mac_rdy !== 4'h0 ||
        ns_adapter_rstn !== 4'h0 || ms_rx_dcc_dll_lock_req !== 4'h0) begin
      n_fail++; $display("FAIL midreset_async: state %0d conf %0b rstn %h want all 0", state_o, i_conf_done, ns_adapter_rstn);
    end
    #1 rst_n = 1'b1;
    step();
    start_i = 1'b1; chnl_mask_i = 4'hF;
    step();
    start_i = 1'b0;
    n_tests++;
    if (state_o !== 3'd1 || cfg_start_o !== 1'b1) begin
      n_fail++; $display("FAIL midreset_restart: state %0d cfg_start %0b want 1/1", state_o, cfg_start_o);
    end
  endtask

  initial begin
    test_reset();
    test_happy();
    test_mask();
    test_timeout_retry();
    test_tie();
    test_link_loss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
